// File: rtl/quiz_pkg.sv
// Shared types and widths for the quiz round sequencer.
package quiz_pkg;
  localparam int NQ      = 16;
  localparam int NUM_W   = 4;
  localparam int HP_W    = 2;
  localparam int SCORE_W = 5;
  localparam int TIME_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    LOAD,
    ASK,
    JUDGE,
    OVER
  } state_t;
endpackage

// File: rtl/quiz_scheduler_if.sv
// Player-control / DB-facing signal bundle for quiz_scheduler, plus FSM debug taps.
interface quiz_scheduler_if;
  import quiz_pkg::*;

  // START and ANS_VALID are single-cycle pulses with no backpressure: START is taken only
  // in IDLE/OVER, ANS_VALID (qualified by ANS_OK) only in ASK; anything else is dropped.
  logic               START;
  logic               ANS_VALID;
  logic               ANS_OK;
  logic [NUM_W-1:0]   NUM;
  logic               Q_VALID;
  logic [TIME_W-1:0]  TIME_LEFT;
  logic [SCORE_W-1:0] SCORE;
  logic [HP_W-1:0]    HP_OUT;
  logic               GAME_OVER;
  logic               CLEAR;
  state_t             STATE;
  logic [NQ-1:0]      USED;

  modport master (
    output START, ANS_VALID, ANS_OK,
    input  NUM, Q_VALID, TIME_LEFT, SCORE, HP_OUT, GAME_OVER, CLEAR, STATE, USED
  );

  modport slave (
    input  START, ANS_VALID, ANS_OK,
    output NUM, Q_VALID, TIME_LEFT, SCORE, HP_OUT, GAME_OVER, CLEAR, STATE, USED
  );
endinterface

// File: rtl/quiz_lfsr4.sv
// Free-running 4-bit maximal-length LFSR (period 15) used as the question start point.
module quiz_lfsr4 #(
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] o_lfsr
);
  logic [3:0] r_lfsr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_lfsr <= SEED;
    else      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/quiz_scheduler.sv
// Quiz round sequencer: picks unused questions, runs the answer timer, keeps score/HP
// and ends the game on HP exhaustion or when every question has been asked.
module quiz_scheduler
  import quiz_pkg::*;
#(
  parameter int         TIME_LIMIT = 1000,
  parameter int         HP_INIT    = 3,
  parameter logic [3:0] LFSR_SEED  = 4'b0001
) (
  input logic             CLK,
  input logic             RST,
  quiz_scheduler_if.slave bus
);
  state_t             r_state;
  state_t             w_next;
  logic [NUM_W-1:0]   w_lfsr;
  logic [NUM_W-1:0]   r_ptr;
  logic [NUM_W-1:0]   r_num;
  logic [NQ-1:0]      r_used;
  logic [TIME_W-1:0]  r_time;
  logic [SCORE_W-1:0] r_score;
  logic [HP_W-1:0]    r_hp;
  logic               r_qv;
  logic               r_go;
  logic               r_clr;
  logic               w_free;
  logic               w_all_used;

  quiz_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK    (CLK),
    .RST    (RST),
    .o_lfsr (w_lfsr)
  );

  assign w_free     = ~r_used[r_ptr];
  assign w_all_used = &r_used;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, OVER: if (bus.START) w_next = PICK;
      PICK:       if (w_free) w_next = LOAD;
      LOAD:       w_next = ASK;
      ASK:        if (bus.ANS_VALID || r_time == '0) w_next = JUDGE;
      JUDGE:      w_next = (r_hp == '0 || w_all_used) ? OVER : PICK;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr   <= '0;
      r_num   <= '0;
      r_used  <= '0;
      r_time  <= '0;
      r_score <= '0;
      r_hp    <= HP_W'(HP_INIT);
      r_qv    <= 1'b0;
      r_go    <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, OVER: begin
          if (bus.START) begin
            r_used  <= '0;
            r_score <= '0;
            r_hp    <= HP_W'(HP_INIT);
            r_go    <= 1'b0;
            r_clr   <= 1'b0;
            r_ptr   <= w_lfsr;
          end
        end
        PICK: begin
          // Linear probe from the random start point until a free slot turns up.
          if (w_free) begin
            r_num          <= r_ptr;
            r_used[r_ptr]  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + NUM_W'(1);
          end
        end
        LOAD: begin
          r_time <= TIME_W'(TIME_LIMIT);
          r_qv   <= 1'b1;
        end
        ASK: begin
          if (r_time != '0) r_time <= r_time - TIME_W'(1);
          // An answer arriving in the last timer cycle beats the timeout.
          if (bus.ANS_VALID) begin
            r_qv <= 1'b0;
            if (bus.ANS_OK) begin
              if (r_score < SCORE_W'(NQ)) r_score <= r_score + SCORE_W'(1);
            end else if (r_hp != '0) begin
              r_hp <= r_hp - HP_W'(1);
            end
          end else if (r_time == '0) begin
            r_qv <= 1'b0;
            if (r_hp != '0) r_hp <= r_hp - HP_W'(1);
          end
        end
        JUDGE: begin
          if (r_hp == '0)      r_go  <= 1'b1;
          else if (w_all_used) r_clr <= 1'b1;
          else                 r_ptr <= w_lfsr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.NUM       = r_num;
    bus.Q_VALID   = r_qv;
    bus.TIME_LEFT = r_time;
    bus.SCORE     = r_score;
    bus.HP_OUT    = r_hp;
    bus.GAME_OVER = r_go;
    bus.CLEAR     = r_clr;
    bus.STATE     = r_state;
    bus.USED      = r_used;
  end
endmodule
